// File: rtl/dcache_pkg.sv
// -----------------------------------------------------------------------------
// dcache_pkg
// Shared types and width helpers for the direct-mapped write-back data cache.
//   dcache_state_t : controller FSM states (IDLE, WRITEBACK, ALLOCATE)
//   ADDR_W, DATA_W : CPU/memory address and data widths
//   off_w/idx_w/tag_w : address-field widths derived from the cache geometry
// -----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    // Word-within-line field width.
    function automatic int off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index field width.
    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag field width: whatever remains above index, word offset and byte offset.
    function automatic int tag_w(input int num_lines, input int words_per_line);
        return ADDR_W - 2 - $clog2(num_lines) - $clog2(words_per_line);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// -----------------------------------------------------------------------------
// dcache_if
// Bundles the CPU-side request bus and the memory-side beat bus of the cache.
//   slave  : cache view  (cpu_* / mem_rdata / mem_ack in; cpu_rdata, cpu_stall,
//            mem_req, mem_we, mem_addr, mem_wdata out)
//   master : core + memory view (directions reversed)
// -----------------------------------------------------------------------------
interface dcache_if;
    import dcache_pkg::*;

    // CPU side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_array.sv
// -----------------------------------------------------------------------------
// dcache_array
// Line storage for the direct-mapped cache: valid, dirty, tag and data words.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rd_index_i, rd_word_i : combinational read port (line metadata + one word)
//   rd_valid_o, rd_dirty_o, rd_tag_o, rd_data_o : read results
//   wr_index_i            : line addressed by both write ports
//   word_we_i, wr_word_i, wr_data_i : synchronous single-word write
//   meta_we_i, meta_valid_i, meta_dirty_i, meta_tag_i : line-metadata write
// -----------------------------------------------------------------------------
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [idx_w(NUM_LINES)-1:0]                 rd_index_i,
    input  logic [off_w(WORDS_PER_LINE)-1:0]            rd_word_i,
    output logic                                        rd_valid_o,
    output logic                                        rd_dirty_o,
    output logic [tag_w(NUM_LINES, WORDS_PER_LINE)-1:0] rd_tag_o,
    output logic [DATA_W-1:0]                           rd_data_o,
    input  logic [idx_w(NUM_LINES)-1:0]                 wr_index_i,
    input  logic                                        word_we_i,
    input  logic [off_w(WORDS_PER_LINE)-1:0]            wr_word_i,
    input  logic [DATA_W-1:0]                           wr_data_i,
    input  logic                                        meta_we_i,
    input  logic                                        meta_valid_i,
    input  logic                                        meta_dirty_i,
    input  logic [tag_w(NUM_LINES, WORDS_PER_LINE)-1:0] meta_tag_i
);

    localparam int TAG = tag_w(NUM_LINES, WORDS_PER_LINE);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG-1:0]       tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_dirty_o = dirty_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_word_i];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_we_i) begin
            valid_q[wr_index_i] <= meta_valid_i;
            dirty_q[wr_index_i] <= meta_dirty_i;
        end
    end

    // NOTE: tag and data arrays carry no reset; clearing valid is enough to make
    // their contents unreachable, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (meta_we_i) begin
            tag_q[wr_index_i] <= meta_tag_i;
        end
        if (word_we_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller. Hits finish
// in the same cycle; misses stall the core while the victim line is written
// back beat by beat (if dirty) and the requested line is refilled.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : dcache_if.slave (CPU request bus + memory beat bus)
//   hit_count, miss_count : saturating statistics, present only when the
//                           DCACHE_STATS_EN macro is defined
// -----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        reset,
    dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF = off_w(WORDS_PER_LINE);
    localparam int IDX = idx_w(NUM_LINES);
    localparam int TAG = tag_w(NUM_LINES, WORDS_PER_LINE);

    // Request address fields
    logic [OFF-1:0] req_word;
    logic [IDX-1:0] req_index;
    logic [TAG-1:0] req_tag;
    logic           unused_byte_offset;

    assign req_word           = bus.cpu_addr[2 +: OFF];
    assign req_index          = bus.cpu_addr[2 + OFF +: IDX];
    assign req_tag            = bus.cpu_addr[ADDR_W-1 -: TAG];
    assign unused_byte_offset = ^bus.cpu_addr[1:0];

    dcache_state_t  state_q, state_d;
    logic [OFF-1:0] beat_q, beat_d;

    // Array ports
    logic [OFF-1:0]    rd_word;
    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG-1:0]    rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              word_we;
    logic [OFF-1:0]    wr_word;
    logic [DATA_W-1:0] wr_data;
    logic              meta_we;
    logic              meta_valid;
    logic              meta_dirty;
    logic [TAG-1:0]    meta_tag;

    // Memory-side outputs
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    logic hit;
    logic last_beat;

    dcache_array #(
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk          (clk),
        .reset        (reset),
        .rd_index_i   (req_index),
        .rd_word_i    (rd_word),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_index_i   (req_index),
        .word_we_i    (word_we),
        .wr_word_i    (wr_word),
        .wr_data_i    (wr_data),
        .meta_we_i    (meta_we),
        .meta_valid_i (meta_valid),
        .meta_dirty_i (meta_dirty),
        .meta_tag_i   (meta_tag)
    );

    assign hit       = bus.cpu_req & rd_valid & (rd_tag == req_tag);
    assign last_beat = (beat_q == OFF'(WORDS_PER_LINE - 1));

    // Load data is only presented for an IDLE-state hit; zero otherwise.
    assign bus.cpu_rdata = ((state_q == IDLE) && hit) ? rd_data : '0;
    assign bus.cpu_stall = (state_q != IDLE) | (bus.cpu_req & ~hit);

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_word    = req_word;
        word_we    = 1'b0;
        wr_word    = req_word;
        wr_data    = bus.cpu_wdata;
        meta_we    = 1'b0;
        meta_valid = 1'b1;
        meta_dirty = 1'b0;
        meta_tag   = req_tag;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (hit) begin
                        if (bus.cpu_we) begin
                            word_we    = 1'b1;
                            meta_we    = 1'b1;
                            meta_dirty = 1'b1;
                        end
                    end else begin
                        beat_d  = '0;
                        state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                // The read port walks the victim line using the beat counter.
                rd_word   = beat_q;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {rd_tag, req_index, beat_q, 2'b00};
                mem_wdata = rd_data;
                if (bus.mem_ack) begin
                    beat_d = beat_q + OFF'(1);
                    if (last_beat) begin
                        // Victim stays valid under its old tag until the refill
                        // completes; only its dirty bit is cleared.
                        meta_we    = 1'b1;
                        meta_dirty = 1'b0;
                        meta_tag   = rd_tag;
                        state_d    = ALLOCATE;
                    end
                end
            end

            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, beat_q, 2'b00};
                if (bus.mem_ack) begin
                    word_we = 1'b1;
                    wr_word = beat_q;
                    wr_data = bus.mem_rdata;
                    beat_d  = beat_q + OFF'(1);
                    if (last_beat) begin
                        meta_we = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if ((state_q == IDLE) && hit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d != IDLE) && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Directed bench for dcache_ctrl: a behavioural memory answers beats after a
// programmable wait, logs every beat, and each scenario task checks the CPU
// stall count, load data and beat addresses/data against hand-derived values.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    logic clk;
    logic reset;

    dcache_if bus();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    dcache_ctrl #(
        .NUM_LINES      (16),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural memory
    int          mem_delay = 0;
    int          wait_cnt  = 0;
    logic        beat_open = 1'b0;
    logic [31:0] beat_addr;
    logic [31:0] beat_wdata;
    logic        beat_we;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    logic [31:0] rd_addr_log [$];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
    endtask

    // Called once per cycle, after the negedge has settled. Acks a beat once it
    // has waited mem_delay cycles, and checks the beat is held steady meanwhile.
    task automatic mem_tick();
        if (bus.mem_req) begin
            if (!beat_open) begin
                beat_open  = 1'b1;
                beat_addr  = bus.mem_addr;
                beat_wdata = bus.mem_wdata;
                beat_we    = bus.mem_we;
            end else begin
                checks++;
                if (bus.mem_addr !== beat_addr || bus.mem_wdata !== beat_wdata || bus.mem_we !== beat_we) begin
                    errors++;
                    $display("FAIL beat_stable: got addr=%h wdata=%h we=%b expected addr=%h wdata=%h we=%b",
                             bus.mem_addr, bus.mem_wdata, bus.mem_we, beat_addr, beat_wdata, beat_we);
                end
            end
            if (wait_cnt == mem_delay) begin
                bus.mem_ack = 1'b1;
                wait_cnt    = 0;
                beat_open   = 1'b0;
                if (bus.mem_we) begin
                    mem_store[bus.mem_addr] = bus.mem_wdata;
                    wr_addr_log.push_back(bus.mem_addr);
                    wr_data_log.push_back(bus.mem_wdata);
                    bus.mem_rdata = 32'h0;
                end else begin
                    bus.mem_rdata = mem_read(bus.mem_addr);
                    rd_addr_log.push_back(bus.mem_addr);
                end
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'h0;
            wait_cnt      = 0;
            beat_open     = 1'b0;
        end
    endtask

    // Issue one request at a negedge and hold it until the cache stops stalling;
    // returns stall cycles, cycles with mem_req high, and the load data seen.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output int stalls, output int mreq, output logic [31:0] rdata);
        stalls        = 0;
        mreq          = 0;
        rdata         = 32'hxxxx_xxxx;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        for (int i = 0; i < 200; i++) begin
            #1;
            mem_tick();
            if (bus.mem_req) mreq++;
            if (!bus.cpu_stall) begin
                rdata = bus.cpu_rdata;
                break;
            end
            stalls++;
            @(negedge clk);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.cpu_we  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.cpu_stall); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.cpu_rdata); end
        @(negedge clk);
        reset = 1'b0;
        // Idle with cpu_req low: no stall, no memory traffic.
        repeat (3) begin
            @(negedge clk);
            #1;
            mem_tick();
            checks++;
            if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: got stall=%b mem_req=%b expected 0/0", bus.cpu_stall, bus.mem_req);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_cold_load();
        int stalls, mreq;
        logic [31:0] rdata;
        mem_delay = 0;
        clear_logs();
        run_req(1'b0, 32'h0000_0040, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 5) begin errors++; $display("FAIL cold_stalls: got %0d expected 5", stalls); end
        checks++; if (rdata !== 32'hA0) begin errors++; $display("FAIL cold_rdata: got %h expected 000000a0", rdata); end
        checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL cold_wr_beats: got %0d expected 0", wr_addr_log.size()); end
        checks++; if (rd_addr_log.size() != 4) begin errors++; $display("FAIL cold_rd_beats: got %0d expected 4", rd_addr_log.size()); end
        for (int i = 0; i < rd_addr_log.size() && i < 4; i++) begin
            checks++;
            if (rd_addr_log[i] !== 32'h40 + 32'(4 * i)) begin
                errors++;
                $display("FAIL cold_rd_addr%0d: got %h expected %h", i, rd_addr_log[i], 32'h40 + 32'(4 * i));
            end
        end
        run_req(1'b0, 32'h0000_004C, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 0 || rdata !== 32'hA3) begin errors++; $display("FAIL hit_last_word: got stalls=%0d rdata=%h expected 0/000000a3", stalls, rdata); end
    endtask

    task automatic test_store_hit();
        int stalls, mreq;
        logic [31:0] rdata;
        clear_logs();
        run_req(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, stalls, mreq, rdata);
        checks++; if (stalls != 0 || mreq != 0) begin errors++; $display("FAIL store_hit: got stalls=%0d mem_req_cycles=%0d expected 0/0", stalls, mreq); end
        run_req(1'b0, 32'h0000_0044, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 0 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_readback: got stalls=%0d rdata=%h expected 0/deadbeef", stalls, rdata); end
        checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL store_no_writethrough: got %0d write beats expected 0", wr_addr_log.size()); end
    endtask

    task automatic test_dirty_evict();
        int stalls, mreq;
        logic [31:0] rdata;
        logic [31:0] exp_wd [4] = '{32'hA0, 32'hDEAD_BEEF, 32'hA2, 32'hA3};
        mem_delay = 0;
        clear_logs();
        run_req(1'b0, 32'h0000_0440, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 9) begin errors++; $display("FAIL evict_stalls: got %0d expected 9", stalls); end
        checks++; if (rdata !== 32'hB0) begin errors++; $display("FAIL evict_rdata: got %h expected 000000b0", rdata); end
        checks++; if (wr_addr_log.size() != 4) begin errors++; $display("FAIL evict_wr_beats: got %0d expected 4", wr_addr_log.size()); end
        for (int i = 0; i < wr_addr_log.size() && i < 4; i++) begin
            checks++;
            if (wr_addr_log[i] !== 32'h40 + 32'(4 * i) || wr_data_log[i] !== exp_wd[i]) begin
                errors++;
                $display("FAIL evict_wr%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, wr_addr_log[i], wr_data_log[i], 32'h40 + 32'(4 * i), exp_wd[i]);
            end
        end
        checks++; if (rd_addr_log.size() != 4) begin errors++; $display("FAIL evict_rd_beats: got %0d expected 4", rd_addr_log.size()); end
        for (int i = 0; i < rd_addr_log.size() && i < 4; i++) begin
            checks++;
            if (rd_addr_log[i] !== 32'h440 + 32'(4 * i)) begin
                errors++;
                $display("FAIL evict_rd_addr%0d: got %h expected %h", i, rd_addr_log[i], 32'h440 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_slow_mem();
        int stalls, mreq;
        logic [31:0] rdata;
        logic [31:0] exp_wd [4] = '{32'hB0, 32'hB1, 32'h1234_5678, 32'hB3};
        mem_delay = 3;
        run_req(1'b1, 32'h0000_0448, 32'h1234_5678, stalls, mreq, rdata);
        checks++; if (stalls != 0) begin errors++; $display("FAIL slow_store_hit: got stalls=%0d expected 0", stalls); end
        clear_logs();
        run_req(1'b0, 32'h0000_0048, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 33) begin errors++; $display("FAIL slow_stalls: got %0d expected 33", stalls); end
        checks++; if (rdata !== 32'hA2) begin errors++; $display("FAIL slow_rdata: got %h expected 000000a2", rdata); end
        checks++; if (wr_addr_log.size() != 4 || rd_addr_log.size() != 4) begin errors++; $display("FAIL slow_beats: got wr=%0d rd=%0d expected 4/4", wr_addr_log.size(), rd_addr_log.size()); end
        for (int i = 0; i < wr_addr_log.size() && i < 4; i++) begin
            checks++;
            if (wr_addr_log[i] !== 32'h440 + 32'(4 * i) || wr_data_log[i] !== exp_wd[i]) begin
                errors++;
                $display("FAIL slow_wr%0d: got addr=%h data=%h expected addr=%h data=%h",
                         i, wr_addr_log[i], wr_data_log[i], 32'h440 + 32'(4 * i), exp_wd[i]);
            end
        end
        run_req(1'b0, 32'h0000_0044, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 0 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL slow_refill_word1: got stalls=%0d rdata=%h expected 0/deadbeef", stalls, rdata); end
        mem_delay = 0;
    endtask

    task automatic test_boundary();
        int stalls, mreq;
        logic [31:0] rdata;
        clear_logs();
        run_req(1'b0, 32'h0000_00FC, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 5 || rdata !== 32'hC0DE_00FC) begin errors++; $display("FAIL last_index: got stalls=%0d rdata=%h expected 5/c0de00fc", stalls, rdata); end
        clear_logs();
        // Same index, all-ones tag: clean victim is replaced without write beats.
        run_req(1'b0, 32'hFFFF_FFF0, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 5 || rdata !== 32'hC0DE_FFF0) begin errors++; $display("FAIL clean_replace: got stalls=%0d rdata=%h expected 5/c0defff0", stalls, rdata); end
        checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL clean_no_wb: got %0d write beats expected 0", wr_addr_log.size()); end
        checks++; if (rd_addr_log.size() != 4) begin errors++; $display("FAIL top_rd_beats: got %0d expected 4", rd_addr_log.size()); end
        else if (rd_addr_log[3] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL top_last_addr: got %h expected fffffffc", rd_addr_log[3]); end
    endtask

    task automatic test_ack_idle();
        int stalls, mreq;
        logic [31:0] rdata;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0) begin
                errors++;
                $display("FAIL idle_ack_ignored: got mem_req=%b stall=%b expected 0/0", bus.mem_req, bus.cpu_stall);
            end
        end
        bus.mem_ack = 1'b0;
        @(negedge clk);
        run_req(1'b0, 32'hFFFF_FFF4, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 0 || mreq != 0 || rdata !== 32'hC0DE_FFF4) begin errors++; $display("FAIL idle_ack_line: got stalls=%0d mreq=%0d rdata=%h expected 0/0/c0defff4", stalls, mreq, rdata); end
    endtask

    task automatic test_reset_mid_miss();
        int stalls, mreq;
        logic [31:0] rdata;
        mem_delay     = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0000_0840;
        #1;
        mem_tick();
        checks++; if (bus.cpu_stall !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL miss_cycle0: got stall=%b mem_req=%b expected 1/0", bus.cpu_stall, bus.mem_req); end
        @(negedge clk);
        #1;
        mem_tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h840) begin errors++; $display("FAIL abort_beat0: got mem_req=%b addr=%h expected 1/00000840", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        mem_tick();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h844) begin errors++; $display("FAIL abort_beat1: got mem_req=%b addr=%h expected 1/00000844", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL abort_mem_req: got %b expected 0", bus.mem_req); end
        bus.cpu_req = 1'b0;
        reset       = 1'b0;
        mem_tick();
        @(negedge clk);
        clear_logs();
        run_req(1'b0, 32'h0000_0840, 32'h0, stalls, mreq, rdata);
        checks++; if (stalls != 5 || rdata !== 32'hC0DE_0840) begin errors++; $display("FAIL after_abort: got stalls=%0d rdata=%h expected 5/c0de0840", stalls, rdata); end
        checks++; if (wr_addr_log.size() != 0) begin errors++; $display("FAIL after_abort_wb: got %0d write beats expected 0", wr_addr_log.size()); end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        int stalls, mreq;
        logic [31:0] rdata;
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL stats_reset: got hit=%0d miss=%0d expected 0/0", hit_count, miss_count); end
        reset = 1'b0;
        @(negedge clk);
        run_req(1'b0, 32'h0000_0040, 32'h0, stalls, mreq, rdata);
        run_req(1'b0, 32'h0000_0044, 32'h0, stalls, mreq, rdata);
        run_req(1'b0, 32'h0000_0048, 32'h0, stalls, mreq, rdata);
        run_req(1'b0, 32'h0000_004C, 32'h0, stalls, mreq, rdata);
        #1;
        checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL stats_miss: got %0d expected 1", miss_count); end
        checks++; if (hit_count !== 32'd4) begin errors++; $display("FAIL stats_hit: got %0d expected 4", hit_count); end
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        mem_store[32'h40]  = 32'hA0;
        mem_store[32'h44]  = 32'hA1;
        mem_store[32'h48]  = 32'hA2;
        mem_store[32'h4C]  = 32'hA3;
        mem_store[32'h440] = 32'hB0;
        mem_store[32'h444] = 32'hB1;
        mem_store[32'h448] = 32'hB2;
        mem_store[32'h44C] = 32'hB3;

        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_slow_mem();
        test_boundary();
        test_ack_idle();
        test_reset_mid_miss();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the execute-stage ALU.
- The ALU result is the load/store address (cpu_addr); cpu_wdata carries store data.
- Hits complete in the same cycle. Misses stall the core while a beat-by-beat handshake with main memory evicts and refills the line.

Parameters:
- NUM_LINES, 16, number of cache lines; power of 2, >= 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of 2, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  load/store request valid
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address (ALUResult); bits [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid when cpu_req & !cpu_we & !cpu_stall
- cpu_stall  out  1  core must hold cpu_* stable while high
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = write beat (eviction), 0 = read beat (refill)
- mem_addr  out  32  word-aligned beat address
- mem_wdata  out  32  write-beat data
- mem_rdata  in  32  read-beat data, valid with mem_ack
- mem_ack  in  1  one-cycle pulse completing the current beat

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE), IDX = log2(NUM_LINES).
  - word = addr[2+OFF-1:2]
  - index = addr[2+OFF+IDX-1:2+OFF]
  - tag = addr[31:2+OFF+IDX]
- Per-line storage: valid, dirty, tag, WORDS_PER_LINE data words.
- hit = cpu_req & valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - hit, load: cpu_rdata = data word, combinational, zero latency; cpu_stall = 0.
  - hit, store: word written and dirty set at the edge; cpu_stall = 0.
  - miss: cpu_stall = 1 in the same cycle.
    - Victim valid & dirty -> WRITEBACK, else -> ALLOCATE.
    - Beat counter cleared to 0.
- WRITEBACK:
  - mem_req = 1, mem_we = 1.
  - mem_addr = {victim tag, index, beat, 2'b00}; mem_wdata = victim word[beat].
  - Each mem_ack increments beat. On ack of the last beat: dirty cleared, beat = 0, -> ALLOCATE.
- ALLOCATE:
  - mem_req = 1, mem_we = 0.
  - mem_addr = {req tag, index, beat, 2'b00}.
  - Each mem_ack writes mem_rdata into word[beat] and increments beat.
  - On ack of the last beat: tag written, valid = 1, dirty = 0, -> IDLE.
  - The request then hits in IDLE; a store completes there and sets dirty.
- cpu_stall = (state != IDLE) | (cpu_req & !hit).
- mem_addr/mem_wdata/mem_we stay stable while mem_req = 1 and mem_ack = 0. Memory may take any number of cycles per beat.
- mem_ack received in IDLE is ignored.
- Minimum miss latency:
  - clean: 1 + WORDS_PER_LINE cycles
  - dirty: 1 + 2*WORDS_PER_LINE cycles
  - each counted with single-cycle acks.
- Beat counter is log2(WORDS_PER_LINE) bits wide. It wraps to 0 on the last beat; no overflow state.
- Reset values:
  - state = IDLE, beat = 0
  - all valid and dirty bits = 0; tags and data arrays not reset
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - cpu_rdata = 0 while no hit
- Reset mid-miss: transfer aborted, mem_req low from the next cycle, pending dirty data discarded.
- cpu_req low in IDLE: cpu_stall = 0, no state change.
- Stores never write through to memory.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count [31:0] and miss_count [31:0].
  - hit_count increments on each IDLE cycle with hit.
  - miss_count increments on each IDLE->WRITEBACK/ALLOCATE transition.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dcache_pkg:
  - dcache_state_t enum (IDLE, WRITEBACK, ALLOCATE)
  - ADDR_W = 32, DATA_W = 32
  - localparam helpers for OFF/IDX/TAG widths
- Sub-module dcache_array:
  - tag/valid/dirty/data storage
  - combinational read port plus one synchronous word-write port and line-metadata write port
- dcache_ctrl holds the FSM, beat counter, hit logic and memory interface.

Test Plan:
- Cold load addr 0x0000_0040, memory returns 0xA0..0xA3 with 1-cycle acks -> 4 read beats at 0x40,0x44,0x48,0x4C; stall 5 cycles; then cpu_rdata = 0xA0.
- Store 0xDEAD_BEEF to 0x44 after that fill -> no stall, no mem_req; subsequent load 0x44 returns 0xDEAD_BEEF same cycle.
- Load 0x0000_0440 (same index, new tag) with line dirty -> 4 write beats at 0x40..0x4C with 0xA0,0xDEAD_BEEF,0xA2,0xA3, then 4 read beats at 0x440..0x44C.
- Memory acks after 3-cycle delay per beat -> mem_addr/mem_wdata stable across wait cycles; total dirty-miss stall = 1 + 8*4 cycles.
- Reset asserted during second refill beat -> mem_req = 0 next cycle; following load to same address misses (valid cleared).
- DCACHE_STATS_EN: 1 miss + 3 hits -> miss_count = 1, hit_count = 4 (includes post-refill hit).
